// File: rtl/water_alarm_pkg.sv
// Shared types, default thresholds and tone helper for the water alarm controller.
package water_alarm_pkg;

    typedef enum logic [1:0] {
        SAFE   = 2'd0,
        WARN   = 2'd1,
        DANGER = 2'd2,
        CRIT   = 2'd3
    } alarm_level_t;

    typedef enum logic {
        UNMUTED = 1'b0,
        MUTED   = 1'b1
    } mute_state_t;

    localparam int DEF_WARN_LVL   = 7;
    localparam int DEF_DANGER_LVL = 11;
    localparam int DEF_CRIT_LVL   = 15;
    localparam int DEF_HYST       = 1;

    function automatic int half_period(input int clk_hz, input int freq_hz);
        return clk_hz / (2 * freq_hz);
    endfunction

endpackage

// File: rtl/water_alarm_ctrl_tone_gen.sv
// Programmable square-wave generator: toggles beep every (half_cnt + 1) enabled cycles.
module tone_gen #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         restart,
    input  logic [W-1:0] half_cnt,
    output logic         beep
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         beep_q, beep_d;

    // half_cnt is the terminal count, i.e. half-period minus one
    always_comb begin
        cnt_d  = cnt_q;
        beep_d = beep_q;
        if (!enable || restart) begin
            cnt_d  = '0;
            beep_d = 1'b0;
        end else if (cnt_q >= half_cnt) begin
            cnt_d  = '0;
            beep_d = ~beep_q;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            beep_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            beep_q <= beep_d;
        end
    end

    assign beep = beep_q;

endmodule

// File: rtl/water_alarm_ctrl.sv
// Water level alarm: dwell-filtered level classification with hysteresis,
// operator mute with timeout, and a single programmable buzzer tone.
module water_alarm_ctrl
    import water_alarm_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int WARN_LVL   = DEF_WARN_LVL,
    parameter int DANGER_LVL = DEF_DANGER_LVL,
    parameter int CRIT_LVL   = DEF_CRIT_LVL,
    parameter int HYST       = DEF_HYST,
    parameter int DWELL_CYC  = 50_000,
    parameter int MUTE_CYC   = 500_000_000,
    parameter int F_WARN     = 100,
    parameter int F_DANGER   = 250,
    parameter int F_CRIT     = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] water_level_int,
    input  logic       mute_req,
    output logic [1:0] alarm_level,
    output logic       alarm_active,
    output logic       muted,
    output logic       beep
);

    localparam int HALF_WARN   = half_period(CLK_HZ, F_WARN);
    localparam int HALF_DANGER = half_period(CLK_HZ, F_DANGER);
    localparam int HALF_CRIT   = half_period(CLK_HZ, F_CRIT);
    localparam int HALF_MAX0   = (HALF_WARN > HALF_DANGER) ? HALF_WARN : HALF_DANGER;
    localparam int HALF_MAX    = (HALF_MAX0 > HALF_CRIT) ? HALF_MAX0 : HALF_CRIT;
    localparam int TONE_W      = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
    localparam int DWELL_W     = $clog2(DWELL_CYC + 1);
    localparam int MUTE_W      = $clog2(MUTE_CYC + 1);

    alarm_level_t      level_q, level_d;
    alarm_level_t      pend_tgt_q, pend_tgt_d;
    alarm_level_t      raw_class, tgt;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    mute_state_t       mute_q, mute_d;
    logic [MUTE_W-1:0] timer_q, timer_d;
    logic              active_q, active_d;
    logic              muted_q, muted_d;
    logic              esc_ok, de_esc_ok, level_chg, escalate;
    logic              tone_en;
    logic [TONE_W-1:0] half_cnt;
    int                level_int;
    int                lower_thr;

    assign level_int = int'(water_level_int);

    always_comb begin
        if (level_int < WARN_LVL)        raw_class = SAFE;
        else if (level_int < DANGER_LVL) raw_class = WARN;
        else if (level_int < CRIT_LVL)   raw_class = DANGER;
        else                             raw_class = CRIT;

        case (level_q)
            WARN:    lower_thr = WARN_LVL;
            DANGER:  lower_thr = DANGER_LVL;
            CRIT:    lower_thr = CRIT_LVL;
            default: lower_thr = 0;
        endcase
    end

    // A bound of zero or below can never be undercut, so that level is sticky
    assign esc_ok    = (raw_class > level_q);
    assign de_esc_ok = (level_q != SAFE) && (level_int < lower_thr - HYST);

    always_comb begin
        dwell_d    = '0;
        pend_tgt_d = pend_tgt_q;
        level_d    = level_q;
        level_chg  = 1'b0;
        escalate   = 1'b0;
        tgt        = esc_ok ? raw_class : alarm_level_t'(level_q - 2'd1);
        if (esc_ok || de_esc_ok) begin
            if (dwell_q != '0 && tgt == pend_tgt_q) begin
                dwell_d = (dwell_q != '1) ? dwell_q + DWELL_W'(1) : dwell_q;
            end else begin
                dwell_d = DWELL_W'(1);
            end
            pend_tgt_d = tgt;
            if (dwell_d >= DWELL_W'(DWELL_CYC)) begin
                level_d   = tgt;
                level_chg = 1'b1;
                escalate  = esc_ok;
                dwell_d   = '0;
            end
        end
    end

    // Escalation or reaching SAFE always lifts the mute; a step down does not
    always_comb begin
        mute_d  = mute_q;
        timer_d = timer_q;
        case (mute_q)
            UNMUTED: begin
                if (mute_req && active_q && !escalate && level_d != SAFE) begin
                    mute_d  = MUTED;
                    timer_d = MUTE_W'(MUTE_CYC);
                end
            end
            MUTED: begin
                if (timer_q == MUTE_W'(1) || escalate || level_d == SAFE) begin
                    mute_d  = UNMUTED;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - MUTE_W'(1);
                end
            end
            default: begin
                mute_d  = UNMUTED;
                timer_d = '0;
            end
        endcase
        active_d = (level_d != SAFE);
        muted_d  = (mute_d == MUTED);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q    <= SAFE;
            pend_tgt_q <= SAFE;
            dwell_q    <= '0;
            mute_q     <= UNMUTED;
            timer_q    <= '0;
            active_q   <= 1'b0;
            muted_q    <= 1'b0;
        end else begin
            level_q    <= level_d;
            pend_tgt_q <= pend_tgt_d;
            dwell_q    <= dwell_d;
            mute_q     <= mute_d;
            timer_q    <= timer_d;
            active_q   <= active_d;
            muted_q    <= muted_d;
        end
    end

    // Holding the tone off through the unmute edge makes the first rise land HALF cycles later
    always_comb begin
        tone_en = (level_q != SAFE) && (mute_q == UNMUTED) && (mute_d == UNMUTED);
        case (level_q)
            WARN:    half_cnt = TONE_W'(HALF_WARN - 1);
            DANGER:  half_cnt = TONE_W'(HALF_DANGER - 1);
            CRIT:    half_cnt = TONE_W'(HALF_CRIT - 1);
            default: half_cnt = '0;
        endcase
    end

    tone_gen #(
        .W (TONE_W)
    ) u_tone_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (tone_en),
        .restart  (level_chg),
        .half_cnt (half_cnt),
        .beep     (beep)
    );

    assign alarm_level  = level_q;
    assign alarm_active = active_q;
    assign muted        = muted_q;

endmodule

// File: tb/tb_water_alarm_ctrl.sv
// Self-checking bench for water_alarm_ctrl: directed vectors, corner sequences
// and randomized traffic compared against a behavioural model.
module tb_water_alarm_ctrl;

    localparam int TB_CLK_HZ = 1000;
    localparam int TB_F_WARN = 100;
    localparam int TB_F_DANGER = 250;
    localparam int TB_F_CRIT = 500;
    localparam int TB_DWELL = 4;
    localparam int TB_MUTE = 50;
    localparam int TB_HYST = 1;

    logic       clk;
    logic       rst_n;
    logic [3:0] water_level_int;
    logic       mute_req;
    logic [1:0] alarm_level;
    logic       alarm_active;
    logic       muted;
    logic       beep;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int m_level = 0;
    int m_run = 0;
    int m_tgt = 0;
    int m_mute_left = 0;
    int m_tone_start = 0;

    typedef struct {
        int water;
        bit mreq;
        bit rstn;
        int lvl;
        int muted;
        int beep;
    } vec_t;

    vec_t vecs[10];

    water_alarm_ctrl #(
        .CLK_HZ     (TB_CLK_HZ),
        .WARN_LVL   (7),
        .DANGER_LVL (11),
        .CRIT_LVL   (15),
        .HYST       (TB_HYST),
        .DWELL_CYC  (TB_DWELL),
        .MUTE_CYC   (TB_MUTE),
        .F_WARN     (TB_F_WARN),
        .F_DANGER   (TB_F_DANGER),
        .F_CRIT     (TB_F_CRIT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .water_level_int (water_level_int),
        .mute_req        (mute_req),
        .alarm_level     (alarm_level),
        .alarm_active    (alarm_active),
        .muted           (muted),
        .beep            (beep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int halfFor(input int lvl);
        case (lvl)
            1: return TB_CLK_HZ / (2 * TB_F_WARN);
            2: return TB_CLK_HZ / (2 * TB_F_DANGER);
            3: return TB_CLK_HZ / (2 * TB_F_CRIT);
            default: return 1;
        endcase
    endfunction

    function automatic int lowerOf(input int lvl);
        case (lvl)
            1: return 7;
            2: return 11;
            3: return 15;
            default: return 0;
        endcase
    endfunction

    function automatic int classOf(input int w);
        if (w < 7) return 0;
        if (w < 11) return 1;
        if (w < 15) return 2;
        return 3;
    endfunction

    function automatic int modelBeep();
        if (m_level == 0 || m_mute_left != 0) return 0;
        return ((cyc - m_tone_start) / halfFor(m_level)) % 2;
    endfunction

    // One clock of the alarm rules, applied to the model state
    task automatic modelStep(input int w, input bit req, input bit rstn);
        int raw, old, tgt;
        bit esc, de, up, changed, unmuted;
        if (!rstn) begin
            m_level = 0;
            m_run = 0;
            m_tgt = 0;
            m_mute_left = 0;
            m_tone_start = cyc;
            return;
        end
        raw = classOf(w);
        old = m_level;
        esc = raw > m_level;
        de = (m_level > 0) && (w < lowerOf(m_level) - TB_HYST);
        tgt = esc ? raw : m_level - 1;
        up = 1'b0;
        changed = 1'b0;
        unmuted = 1'b0;
        if (esc || de) begin
            m_run = (m_run > 0 && tgt == m_tgt) ? m_run + 1 : 1;
            m_tgt = tgt;
        end else begin
            m_run = 0;
        end
        if (m_run >= TB_DWELL) begin
            up = tgt > m_level;
            m_level = tgt;
            m_run = 0;
            changed = 1'b1;
        end
        if (m_mute_left > 0) begin
            if (up || m_level == 0) begin
                m_mute_left = 0;
                unmuted = 1'b1;
            end else begin
                m_mute_left--;
                if (m_mute_left == 0) unmuted = 1'b1;
            end
        end else if (req && old > 0 && !up && m_level > 0) begin
            m_mute_left = TB_MUTE;
        end
        if (changed || unmuted) m_tone_start = cyc;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int w, input bit req, input bit rstn);
        water_level_int = 4'(w);
        mute_req = req;
        rst_n = rstn;
        @(posedge clk);
        #1;
        cyc++;
        modelStep(w, req, rstn);
        checkOutput("model_level", int'(alarm_level), m_level);
        checkOutput("model_active", int'(alarm_active), (m_level != 0) ? 1 : 0);
        checkOutput("model_muted", int'(muted), (m_mute_left != 0) ? 1 : 0);
        checkOutput("model_beep", int'(beep), modelBeep());
    endtask

    initial begin
        int warn_cyc;
        int rise_cyc;
        bit prev_beep;

        water_level_int = 4'd15;
        mute_req = 1'b0;
        rst_n = 1'b0;

        vecs[0] = '{15, 1'b0, 1'b0, 0, 0, 0};
        vecs[1] = '{15, 1'b0, 1'b0, 0, 0, 0};
        vecs[2] = '{15, 1'b0, 1'b0, 0, 0, 0};
        vecs[3] = '{15, 1'b0, 1'b1, 0, 0, 0};
        vecs[4] = '{15, 1'b0, 1'b1, 0, 0, 0};
        vecs[5] = '{15, 1'b0, 1'b1, 0, 0, 0};
        vecs[6] = '{15, 1'b0, 1'b1, 3, 0, 0};
        vecs[7] = '{15, 1'b0, 1'b1, 3, 0, 1};
        vecs[8] = '{15, 1'b0, 1'b1, 3, 0, 0};
        vecs[9] = '{15, 1'b0, 1'b1, 3, 0, 1};

        $display("[TB] reset and escalation vectors");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].water, vecs[i].mreq, vecs[i].rstn);
            checkOutput("vec_level", int'(alarm_level), vecs[i].lvl);
            checkOutput("vec_active", int'(alarm_active), (vecs[i].lvl != 0) ? 1 : 0);
            checkOutput("vec_muted", int'(muted), vecs[i].muted);
            checkOutput("vec_beep", int'(beep), vecs[i].beep);
        end

        $display("[TB] glitch filtering");
        for (int i = 0; i < 8; i++) applyStimulus(8, 1'b0, 1'b1);
        checkOutput("reach_warn", int'(alarm_level), 1);
        warn_cyc = cyc;
        for (int i = 0; i < 12; i++) applyStimulus(8, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(12, 1'b0, 1'b1);
        checkOutput("glitch_hold", int'(alarm_level), 1);
        rise_cyc = -1;
        prev_beep = beep;
        for (int i = 0; i < 20 && rise_cyc < 0; i++) begin
            applyStimulus(8, 1'b0, 1'b1);
            if (beep && !prev_beep) rise_cyc = cyc;
            prev_beep = beep;
        end
        checkOutput("glitch_rise_seen", (rise_cyc >= 0) ? 1 : 0, 1);
        checkOutput("glitch_phase", (rise_cyc - warn_cyc) % 10, 5);
        checkOutput("glitch_level", int'(alarm_level), 1);

        $display("[TB] hysteresis");
        for (int i = 0; i < 20; i++) applyStimulus(6, 1'b0, 1'b1);
        checkOutput("hyst_hold", int'(alarm_level), 1);
        for (int i = 0; i < 3; i++) applyStimulus(5, 1'b0, 1'b1);
        checkOutput("hyst_pre_drop", int'(alarm_level), 1);
        applyStimulus(5, 1'b0, 1'b1);
        checkOutput("hyst_safe", int'(alarm_level), 0);
        checkOutput("hyst_beep", int'(beep), 0);

        $display("[TB] stepwise de-escalation");
        for (int i = 0; i < 4; i++) applyStimulus(15, 1'b0, 1'b1);
        checkOutput("step_crit", int'(alarm_level), 3);
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(0, 1'b0, 1'b1);
            if (i == 3) checkOutput("step_c3", int'(alarm_level), 3);
            if (i == 4) checkOutput("step_c4", int'(alarm_level), 2);
            if (i == 8) checkOutput("step_c8", int'(alarm_level), 1);
            if (i == 12) checkOutput("step_c12", int'(alarm_level), 0);
        end

        $display("[TB] mute with timeout");
        for (int i = 0; i < 10; i++) applyStimulus(12, 1'b0, 1'b1);
        checkOutput("mute_pre_level", int'(alarm_level), 2);
        applyStimulus(12, 1'b1, 1'b1);
        checkOutput("mute_set", int'(muted), 1);
        checkOutput("mute_beep_off", int'(beep), 0);
        for (int i = 1; i <= 49; i++) applyStimulus(12, 1'b0, 1'b1);
        checkOutput("mute_still_on", int'(muted), 1);
        applyStimulus(12, 1'b0, 1'b1);
        checkOutput("mute_expired", int'(muted), 0);
        checkOutput("unmute_beep0", int'(beep), 0);
        applyStimulus(12, 1'b0, 1'b1);
        checkOutput("unmute_beep1", int'(beep), 0);
        applyStimulus(12, 1'b0, 1'b1);
        checkOutput("unmute_beep_rise", int'(beep), 1);

        $display("[TB] mute cut short by escalation");
        applyStimulus(12, 1'b1, 1'b1);
        checkOutput("remute_set", int'(muted), 1);
        for (int i = 0; i < 9; i++) applyStimulus(12, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(15, 1'b0, 1'b1);
        checkOutput("esc_pre_muted", int'(muted), 1);
        checkOutput("esc_pre_level", int'(alarm_level), 2);
        applyStimulus(15, 1'b0, 1'b1);
        checkOutput("esc_level", int'(alarm_level), 3);
        checkOutput("esc_unmuted", int'(muted), 0);

        $display("[TB] mute request while safe");
        for (int i = 0; i < 12; i++) applyStimulus(0, 1'b0, 1'b1);
        checkOutput("safe_level", int'(alarm_level), 0);
        applyStimulus(0, 1'b1, 1'b1);
        checkOutput("safe_mute_ignored", int'(muted), 0);

        $display("[TB] reset during mute");
        for (int i = 0; i < 4; i++) applyStimulus(12, 1'b0, 1'b1);
        applyStimulus(12, 1'b1, 1'b1);
        checkOutput("rst_pre_muted", int'(muted), 1);
        for (int i = 0; i < 5; i++) applyStimulus(12, 1'b0, 1'b1);
        applyStimulus(12, 1'b0, 1'b0);
        checkOutput("rst_muted", int'(muted), 0);
        checkOutput("rst_level", int'(alarm_level), 0);
        checkOutput("rst_active", int'(alarm_active), 0);
        for (int i = 0; i < 3; i++) applyStimulus(12, 1'b0, 1'b1);
        checkOutput("rst_no_residue", int'(alarm_level), 0);
        applyStimulus(12, 1'b0, 1'b1);
        checkOutput("rst_reescalate", int'(alarm_level), 2);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 300; n++) begin
            int w;
            int hold;
            w = $urandom_range(0, 15);
            hold = $urandom_range(1, 9);
            for (int h = 0; h < hold; h++) begin
                applyStimulus(w, ($urandom_range(0, 19) == 0), ($urandom_range(0, 299) != 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
